// File: rtl/avalon_burst_ram_slave.sv
// Avalon-MM burst responder over a single-port word RAM; reads return one word per cycle
// after READ_LATENCY, writes take one word per asserted beat.
module avalon_burst_ram_slave #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic [4:0]  av_burstcount,
  input  logic        av_beginbursttransfer,
  output logic        av_waitrequest,
  output logic [31:0] av_readdata,
  output logic        av_readdatavalid
);

  localparam int AW = DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [4:0] MAX_BC = 5'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [4:0]      rem_q, rem_d;
  logic [31:0]     mem [DEPTH];
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]     dat_q [READ_LATENCY];

  logic [AW-1:0]   cmd_idx;
  logic [4:0]      cmd_cnt;
  logic            issue;
  logic [AW-1:0]   rd_idx;
  logic            we;
  logic [AW-1:0]   wr_idx;
  logic            pend;
  logic            unused_ok;

  assign unused_ok = ^{av_beginbursttransfer, av_address[31:AW+2], av_address[1:0]};
  assign cmd_idx   = av_address[AW+1:2];

  always_comb begin
    cmd_cnt = av_burstcount;
    if (av_burstcount == 5'd0) begin
      cmd_cnt = 5'd1;
    end else if (av_burstcount > MAX_BC) begin
      cmd_cnt = MAX_BC;
    end
  end

  // Beats still travelling through the early latency stages keep RD busy.
  always_comb begin
    pend = 1'b0;
    for (int k = 0; k < READ_LATENCY - 1; k++) begin
      pend = pend | vld_q[k];
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    rem_d          = rem_q;
    issue          = 1'b0;
    rd_idx         = idx_q;
    we             = 1'b0;
    wr_idx         = idx_q;
    av_waitrequest = 1'b0;
    case (state_q)
      IDLE: begin
        if (av_read) begin
          issue   = 1'b1;
          rd_idx  = cmd_idx;
          idx_d   = cmd_idx + 1'b1;
          rem_d   = cmd_cnt - 5'd1;
          state_d = RD;
        end else if (av_write) begin
          we     = 1'b1;
          wr_idx = cmd_idx;
          if (cmd_cnt > 5'd1) begin
            idx_d   = cmd_idx + 1'b1;
            rem_d   = cmd_cnt - 5'd1;
            state_d = WR;
          end
        end
      end
      RD: begin
        av_waitrequest = 1'b1;
        if (rem_q != 5'd0) begin
          issue = 1'b1;
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 5'd1;
        end else if (!pend) begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (av_write) begin
          we    = 1'b1;
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= av_writedata;
    end
  end

  // Each stage only loads on a valid beat, so the output stage holds the last word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      if (issue) begin
        dat_q[0] <= mem[rd_idx];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign av_readdatavalid = vld_q[READ_LATENCY-1];
  assign av_readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// Directed bench: two responders (read latency 1 and 3) share one stimulus stream and are
// checked cycle by cycle against a word model of the RAM.
module tb_avalon_burst_ram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [4:0]  av_burstcount;
  logic        av_beginbursttransfer;
  logic        wr1, rdv1, wr3, rdv3;
  logic [31:0] rdd1, rdd3;

  logic [31:0] model [1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_burst_ram_slave #(.DEPTH_LOG2(10), .READ_LATENCY(1), .MAX_BURST(16)) u_dut1 (
    .clk(clk), .resetn(resetn), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_writedata(av_writedata), .av_burstcount(av_burstcount),
    .av_beginbursttransfer(av_beginbursttransfer), .av_waitrequest(wr1),
    .av_readdata(rdd1), .av_readdatavalid(rdv1)
  );

  avalon_burst_ram_slave #(.DEPTH_LOG2(10), .READ_LATENCY(3), .MAX_BURST(16)) u_dut3 (
    .clk(clk), .resetn(resetn), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_writedata(av_writedata), .av_burstcount(av_burstcount),
    .av_beginbursttransfer(av_beginbursttransfer), .av_waitrequest(wr3),
    .av_readdata(rdd3), .av_readdatavalid(rdv3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drives an n-beat write burst; an optional 2-cycle stall before beat stall_at and an
  // illegal av_read on beat rd_at. With chain=1 the bus is left for the next command.
  task automatic wr_burst(input logic [31:0] addr, input int n, input logic [31:0] d0,
                          input int stall_at, input int rd_at, input bit chain);
    int base;
    base = int'((addr >> 2) & 32'h3FF);
    @(negedge clk);
    chk("wr_start_wait1", {31'd0, wr1}, 32'd0);
    chk("wr_start_wait3", {31'd0, wr3}, 32'd0);
    av_address = addr; av_burstcount = 5'(n); av_write = 1'b1; av_read = 1'b0;
    av_beginbursttransfer = 1'b1; av_writedata = d0;
    model[base] = d0;
    for (int i = 1; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          av_write = 1'b0; av_beginbursttransfer = 1'b0;
        end
      end
      @(negedge clk);
      chk("wr_beat_wait1", {31'd0, wr1}, 32'd0);
      chk("wr_beat_wait3", {31'd0, wr3}, 32'd0);
      av_beginbursttransfer = 1'b0;
      av_write = 1'b1; av_writedata = d0 + i; av_read = (i == rd_at);
      av_address = 32'h0000_0010; av_burstcount = 5'd1;
      model[(base + i) % 1024] = d0 + i;
    end
    if (!chain) begin
      @(negedge clk);
      av_write = 1'b0; av_read = 1'b0;
    end
  endtask

  // Issues one read (optionally with av_write also high) and checks every cycle of both
  // responders until the latency-3 one is idle again.
  task automatic rd_burst(input logic [31:0] addr, input logic [4:0] bc, input int n,
                          input bit wr_too);
    int base;
    bit e1, e3;
    base = int'((addr >> 2) & 32'h3FF);
    @(negedge clk);
    chk("rd_idle_wait1", {31'd0, wr1}, 32'd0);
    chk("rd_idle_wait3", {31'd0, wr3}, 32'd0);
    av_address = addr; av_burstcount = bc; av_read = 1'b1; av_write = wr_too;
    av_writedata = 32'h5A5A_5A5A; av_beginbursttransfer = 1'b1;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      av_read = 1'b0; av_write = 1'b0; av_beginbursttransfer = 1'b0;
      e1 = (k <= n);
      e3 = (k >= 3) && (k <= n + 2);
      chk("rdv_lat1", {31'd0, rdv1}, {31'd0, e1});
      chk("rdv_lat3", {31'd0, rdv3}, {31'd0, e3});
      if (e1) chk("rdd_lat1", rdd1, model[(base + k - 1) % 1024]);
      if (e3) chk("rdd_lat3", rdd3, model[(base + k - 3) % 1024]);
      chk("rd_wait1", {31'd0, wr1}, {31'd0, k <= n});
      chk("rd_wait3", {31'd0, wr3}, {31'd0, k <= n + 2});
    end
    chk("hold_lat1", rdd1, model[(base + n - 1) % 1024]);
    chk("hold_lat3", rdd3, model[(base + n - 1) % 1024]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int stray;
    resetn = 1'b0; av_address = '0; av_read = 1'b0; av_write = 1'b0;
    av_writedata = '0; av_burstcount = '0; av_beginbursttransfer = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wait1", {31'd0, wr1}, 32'd0);
    chk("rst_wait3", {31'd0, wr3}, 32'd0);
    chk("rst_vld1", {31'd0, rdv1}, 32'd0);
    chk("rst_vld3", {31'd0, rdv3}, 32'd0);
    chk("rst_data1", rdd1, 32'd0);
    chk("rst_data3", rdd3, 32'd0);
    resetn = 1'b1;

    // single write then a read of the same word in the very next cycle
    wr_burst(32'h10, 1, 32'hDEAD_BEEF, -1, -1, 1'b1);
    rd_burst(32'h10, 5'd1, 1, 1'b0);

    // stalled 8-beat write burst, then 8-beat read back
    wr_burst(32'h100, 8, 32'd0, 4, -1, 1'b0);
    rd_burst(32'h100, 5'd8, 8, 1'b0);

    // wrap across the top of the RAM; upper address bits ignored
    wr_burst(32'h0000_0FF0, 16, 32'hA000_0000, -1, -1, 1'b0);
    rd_burst(32'hC000_0FF0, 5'd16, 16, 1'b0);

    // oversize burstcount clamps to 16, zero burstcount means one beat
    rd_burst(32'h0000_0FF0, 5'd31, 16, 1'b0);
    rd_burst(32'h10, 5'd0, 1, 1'b0);

    // read and write together: read wins, write is dropped
    rd_burst(32'h10, 5'd1, 1, 1'b1);
    rd_burst(32'h10, 5'd1, 1, 1'b0);

    // av_read during a write burst is ignored
    wr_burst(32'h200, 4, 32'h1111_0000, -1, 2, 1'b0);
    rd_burst(32'h200, 5'd4, 4, 1'b0);

    // reset during the fifth beat of a 16-beat read
    @(negedge clk);
    av_address = 32'h100; av_burstcount = 5'd16; av_read = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      av_read = 1'b0;
    end
    chk("pre_rst_vld1", {31'd0, rdv1}, 32'd1);
    chk("pre_rst_data1", rdd1, model[68]);
    resetn = 1'b0;
    #1;
    chk("mid_rst_vld1", {31'd0, rdv1}, 32'd0);
    chk("mid_rst_vld3", {31'd0, rdv3}, 32'd0);
    chk("mid_rst_wait1", {31'd0, wr1}, 32'd0);
    chk("mid_rst_wait3", {31'd0, wr3}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rdv1 || rdv3 || wr1 || wr3) stray++;
    end
    chk("post_rst_stray", stray, 32'd0);
    rd_burst(32'h100, 5'd8, 8, 1'b0);
    rd_burst(32'h10, 5'd1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
